// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: uniform bank of inter-stage pipeline registers.
//
// Register 0 is the youngest (nearest fetch). Each register carries a WIDTH-bit
// payload and a valid bit. It can hold, take a bubble, or load the incoming slice.
// The highest asserted stall bit wins: that register bubbles and every younger
// register holds. A global freeze holds everything.
//
// Optional feature macro: PIPE_REG_STATS_EN adds stall_cycles and bubble_count
// statistics counters with a stats_clr input. When the macro is undefined those
// ports and counters do not exist.
module pipe_reg_chain #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned WIDTH  = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    freeze,
  input  logic [STAGES-1:0]       stall,
  input  logic [STAGES-1:0]       flush,
  input  logic [STAGES-1:0]       valid_n,
  input  logic [STAGES*WIDTH-1:0] data_n,
  output logic [STAGES-1:0]       valid,
  output logic [STAGES*WIDTH-1:0] data,
  output logic [STAGES-1:0]       advance,
  output logic                    front_en
`ifdef PIPE_REG_STATS_EN
  ,
  input  logic                    stats_clr,
  output logic [31:0]             stall_cycles,
  output logic [31:0]             bubble_count
`endif
);

  logic [STAGES*WIDTH-1:0] data_q;
  logic [STAGES-1:0]       valid_q;

  // stall_above[k]: some stall bit with index > k is set, so register k must hold.
  logic [STAGES-1:0] stall_above;
  // bubble_sel[k]: register k takes a bubble if it advances this cycle.
  logic [STAGES-1:0] bubble_sel;
  // bubble_load[k]: register k actually captures a bubble this cycle.
  logic [STAGES-1:0] bubble_load;
  logic              stall_any;

  assign stall_any = |stall;

  // Stall arbitration: find registers below the highest stall bit.
  always_comb begin
    stall_above = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      for (int unsigned j = k + 1; j < STAGES; j++) begin
        stall_above[k] = stall_above[k] | stall[j];
      end
    end
  end

  // Per-register control: advance strobes and bubble selection.
  always_comb begin
    advance     = '0;
    bubble_sel  = '0;
    bubble_load = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      advance[k]     = !RST && !freeze && !stall_above[k];
      // A stall bit that is not subsumed marks the bubbling register; flush adds to it.
      bubble_sel[k]  = (stall[k] && !stall_above[k]) || flush[k];
      bubble_load[k] = advance[k] && bubble_sel[k];
    end
  end

  // Fetch may only move when nothing in the pipe is held.
  always_comb begin
    front_en = !RST && !freeze && !stall_any;
  end

  // Register bank: clear on reset, otherwise bubble or load when advancing.
  for (genvar k = 0; k < STAGES; k++) begin : g_reg
    always_ff @(posedge CLK) begin
      if (RST) begin
        data_q[k*WIDTH +: WIDTH] <= '0;
        valid_q[k]               <= 1'b0;
      end else if (advance[k]) begin
        if (bubble_sel[k]) begin
          data_q[k*WIDTH +: WIDTH] <= '0;
          valid_q[k]               <= 1'b0;
        end else begin
          data_q[k*WIDTH +: WIDTH] <= data_n[k*WIDTH +: WIDTH];
          valid_q[k]               <= valid_n[k];
        end
      end
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

`ifdef PIPE_REG_STATS_EN
  logic [31:0] stall_cnt_q,  stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] bubble_inc;
  logic [32:0] bubble_sum;

  // Count registers taking a bubble this cycle.
  always_comb begin
    bubble_inc = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      bubble_inc = bubble_inc + 32'(bubble_load[k]);
    end
  end

  // Saturating next-state for both counters; clear wins over increment.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    bubble_sum   = {1'b0, bubble_cnt_q} + {1'b0, bubble_inc};
    if (stats_clr) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if ((freeze || stall_any) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
      bubble_cnt_d = bubble_sum[32] ? 32'hFFFF_FFFF : bubble_sum[31:0];
    end
  end

  // Statistics registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain (STAGES=4, WIDTH=8).
module tb_pipe_reg_chain;
  localparam int unsigned S = 4;
  localparam int unsigned W = 8;

  logic           CLK = 1'b0;
  logic           RST;
  logic           freeze;
  logic [S-1:0]   stall;
  logic [S-1:0]   flush;
  logic [S-1:0]   valid_n;
  logic [S*W-1:0] data_n;
  logic [S-1:0]   valid;
  logic [S*W-1:0] data;
  logic [S-1:0]   advance;
  logic           front_en;
  logic           stats_clr;
`ifdef PIPE_REG_STATS_EN
  logic [31:0]    stall_cycles;
  logic [31:0]    bubble_count;
`endif

  pipe_reg_chain #(
    .STAGES(S),
    .WIDTH (W)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .freeze  (freeze),
    .stall   (stall),
    .flush   (flush),
    .valid_n (valid_n),
    .data_n  (data_n),
    .valid   (valid),
    .data    (data),
    .advance (advance),
    .front_en(front_en)
`ifdef PIPE_REG_STATS_EN
    ,
    .stats_clr   (stats_clr),
    .stall_cycles(stall_cycles),
    .bubble_count(bubble_count)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [W-1:0]    m_data [S];
  logic [S-1:0]    m_valid;
  longint unsigned m_sc;
  longint unsigned m_bc;

  function automatic int top_stall(input logic [S-1:0] st);
    int s;
    s = -1;
    for (int k = 0; k < int'(S); k++) if (st[k]) s = k;
    return s;
  endfunction

  function automatic logic [S-1:0] exp_adv(input logic r, input logic fr, input logic [S-1:0] st);
    logic [S-1:0] a;
    int s;
    a = '0;
    s = top_stall(st);
    if (!r && !fr) begin
      for (int k = 0; k < int'(S); k++) a[k] = !(s >= 0 && k < s);
    end
    return a;
  endfunction

  function automatic logic exp_front(input logic r, input logic fr, input logic [S-1:0] st);
    return !r && !fr && (st == '0);
  endfunction

  function automatic logic [S*W-1:0] m_data_flat();
    logic [S*W-1:0] f;
    for (int k = 0; k < int'(S); k++) f[k*W +: W] = m_data[k];
    return f;
  endfunction

  // Apply the register rules for one rising edge to the model.
  task automatic model_edge();
    int s;
    int nb;
    longint unsigned inc;
    nb = 0;
    if (RST) begin
      for (int k = 0; k < int'(S); k++) m_data[k] = '0;
      m_valid = '0;
      m_sc = 0;
      m_bc = 0;
    end else begin
      if (!freeze) begin
        s = top_stall(stall);
        for (int k = 0; k < int'(S); k++) begin
          if (s >= 0 && k < s) begin
            // hold
          end else if (k == s || flush[k]) begin
            m_data[k] = '0;
            m_valid[k] = 1'b0;
            nb++;
          end else begin
            m_data[k] = data_n[k*W +: W];
            m_valid[k] = valid_n[k];
          end
        end
      end
      if (stats_clr) begin
        m_sc = 0;
        m_bc = 0;
      end else begin
        inc = (freeze || stall != '0) ? 1 : 0;
        m_sc = (m_sc + inc > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_sc + inc;
        m_bc = (m_bc + longint'(nb) > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_bc + longint'(nb);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    freeze    = 1'b0;
    stall     = '0;
    flush     = '0;
    stats_clr = 1'b0;
  endtask

  task automatic test_reset();
    RST     = 1'b1;
    idle_inputs();
    data_n  = {S{8'hAA}};
    valid_n = S'($urandom);
    tick();
    tick();
    checks++;
    if (data !== '0 || valid !== '0) begin
      errors++;
      $display("FAIL reset_regs data=%h valid=%b expected data=0 valid=0", data, valid);
    end
    checks++;
    if (advance !== '0 || front_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl advance=%b front_en=%b expected 0000/0", advance, front_en);
    end
    RST = 1'b0;
    valid_n = S'($urandom);
    tick();
    checks++;
    if (data !== {S{8'hAA}} || valid !== valid_n) begin
      errors++;
      $display("FAIL reset_release data=%h valid=%b expected data=aaaaaaaa valid=%b",
               data, valid, valid_n);
    end
  endtask

  task automatic test_flow();
    idle_inputs();
    data_n  = {8'h13, 8'h12, 8'h11, 8'h10};
    valid_n = 4'b1111;
    #1;
    checks++;
    if (advance !== 4'b1111 || front_en !== 1'b1) begin
      errors++;
      $display("FAIL flow_ctrl advance=%b front_en=%b expected 1111/1", advance, front_en);
    end
    tick();
    checks++;
    if (data !== 32'h1312_1110 || valid !== 4'b1111) begin
      errors++;
      $display("FAIL flow_data data=%h valid=%b expected 13121110/1111", data, valid);
    end
    for (int i = 0; i < 4; i++) begin
      data_n  = $urandom;
      valid_n = S'($urandom);
      tick();
      checks++;
      if (data !== m_data_flat() || valid !== m_valid) begin
        errors++;
        $display("FAIL flow_stream data=%h valid=%b expected %h/%b",
                 data, valid, m_data_flat(), m_valid);
      end
    end
  endtask

  task automatic test_stall_arb();
    logic [S*W-1:0] nd;
    idle_inputs();
    data_n  = {8'h04, 8'h03, 8'h02, 8'h01};
    valid_n = 4'b1111;
    tick();
    nd = $urandom;
    data_n  = nd;
    valid_n = 4'b1111;
    stall   = 4'b0101;
    #1;
    checks++;
    if (advance !== 4'b1100 || front_en !== 1'b0) begin
      errors++;
      $display("FAIL stall_ctrl advance=%b front_en=%b expected 1100/0", advance, front_en);
    end
    tick();
    checks++;
    if (data[2*W +: W] !== 8'h00 || valid[2] !== 1'b0) begin
      errors++;
      $display("FAIL stall_bubble reg2=%h/%b expected 00/0", data[2*W +: W], valid[2]);
    end
    checks++;
    if (data[15:0] !== 16'h0201 || valid[1:0] !== 2'b11) begin
      errors++;
      $display("FAIL stall_hold reg1_0=%h/%b expected 0201/11", data[15:0], valid[1:0]);
    end
    checks++;
    if (data[3*W +: W] !== nd[3*W +: W] || valid[3] !== 1'b1) begin
      errors++;
      $display("FAIL stall_load reg3=%h/%b expected %h/1", data[3*W +: W], valid[3],
               nd[3*W +: W]);
    end
  endtask

  task automatic test_hold_flush();
    idle_inputs();
    data_n  = {8'h44, 8'h33, 8'h22, 8'h11};
    valid_n = 4'b1111;
    tick();
    data_n = $urandom;
    stall  = 4'b0100;
    flush  = 4'b0011;
    tick();
    checks++;
    if (data[15:0] !== 16'h2211 || valid[1:0] !== 2'b11) begin
      errors++;
      $display("FAIL hold_beats_flush reg1_0=%h/%b expected 2211/11", data[15:0], valid[1:0]);
    end
    stall = '0;
    tick();
    checks++;
    if (data[15:0] !== 16'h0000 || valid[1:0] !== 2'b00) begin
      errors++;
      $display("FAIL flush_applies reg1_0=%h/%b expected 0000/00", data[15:0], valid[1:0]);
    end
    checks++;
    if (data !== m_data_flat() || valid !== m_valid) begin
      errors++;
      $display("FAIL flush_all data=%h valid=%b expected %h/%b",
               data, valid, m_data_flat(), m_valid);
    end
  endtask

  task automatic test_freeze();
    logic [S*W-1:0] snap_d;
    logic [S-1:0]   snap_v;
    idle_inputs();
    data_n  = $urandom;
    valid_n = 4'b1111;
    tick();
    snap_d = data;
    snap_v = valid;
    freeze = 1'b1;
    stall  = 4'b1000;
    flush  = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      data_n  = $urandom;
      valid_n = S'($urandom);
      #1;
      checks++;
      if (advance !== 4'b0000 || front_en !== 1'b0) begin
        errors++;
        $display("FAIL freeze_ctrl advance=%b front_en=%b expected 0000/0", advance, front_en);
      end
      tick();
      checks++;
      if (data !== snap_d || valid !== snap_v) begin
        errors++;
        $display("FAIL freeze_hold data=%h valid=%b expected %h/%b", data, valid, snap_d, snap_v);
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [S-1:0] ea;
    logic         ef;
    for (int i = 0; i < 300; i++) begin
      RST       = ($urandom_range(0, 15) == 0);
      freeze    = ($urandom_range(0, 7) == 0);
      stall     = ($urandom_range(0, 2) == 0) ? S'($urandom) : '0;
      flush     = ($urandom_range(0, 2) == 0) ? S'($urandom) : '0;
      stats_clr = ($urandom_range(0, 31) == 0);
      data_n    = $urandom;
      valid_n   = S'($urandom);
      #1;
      ea = exp_adv(RST, freeze, stall);
      ef = exp_front(RST, freeze, stall);
      checks++;
      if (advance !== ea || front_en !== ef) begin
        errors++;
        $display("FAIL random_ctrl cyc=%0d advance=%b front_en=%b expected %b/%b",
                 i, advance, front_en, ea, ef);
      end
      tick();
      checks++;
      if (data !== m_data_flat() || valid !== m_valid) begin
        errors++;
        $display("FAIL random_regs cyc=%0d data=%h valid=%b expected %h/%b",
                 i, data, valid, m_data_flat(), m_valid);
      end
`ifdef PIPE_REG_STATS_EN
      checks++;
      if (stall_cycles !== m_sc[31:0] || bubble_count !== m_bc[31:0]) begin
        errors++;
        $display("FAIL random_stats cyc=%0d stall_cycles=%0d bubble_count=%0d expected %0d/%0d",
                 i, stall_cycles, bubble_count, m_sc, m_bc);
      end
`endif
    end
    RST = 1'b0;
    idle_inputs();
  endtask

`ifdef PIPE_REG_STATS_EN
  task automatic test_stats();
    idle_inputs();
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    stall = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      data_n = $urandom;
      tick();
    end
    checks++;
    if (stall_cycles !== 32'd5 || bubble_count !== 32'd5) begin
      errors++;
      $display("FAIL stats_count stall_cycles=%0d bubble_count=%0d expected 5/5",
               stall_cycles, bubble_count);
    end
    stall = '0;
    dut.bubble_cnt_q = 32'hFFFF_FFFE;
    m_bc = 64'hFFFF_FFFE;
    flush = 4'b1111;
    tick();
    checks++;
    if (bubble_count !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL stats_saturate bubble_count=%h expected ffffffff", bubble_count);
    end
    flush = '0;
    stall = 4'b0001;
    stats_clr = 1'b1;
    tick();
    checks++;
    if (stall_cycles !== 32'd0 || bubble_count !== 32'd0) begin
      errors++;
      $display("FAIL stats_clear stall_cycles=%0d bubble_count=%0d expected 0/0",
               stall_cycles, bubble_count);
    end
    idle_inputs();
  endtask
`endif

  initial begin
    RST = 1'b1;
    idle_inputs();
    data_n  = '0;
    valid_n = '0;
    m_valid = '0;
    m_sc = 0;
    m_bc = 0;
    for (int k = 0; k < int'(S); k++) m_data[k] = '0;
    test_reset();
    test_flow();
    test_stall_arb();
    test_hold_flush();
    test_freeze();
`ifdef PIPE_REG_STATS_EN
    test_stats();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
